// File: rtl/ahb_arbiter_param.sv
// ahb_arbiter_param
//
// Parametrised AHB bus arbiter for up to 16 masters. Supports fixed-priority or
// round-robin arbitration, locked-transfer hold, SPLIT masking with HSPLIT release,
// and a default-master fallback when no eligible master is requesting.
//
// Parameters:
//   NUM_MASTERS    - number of masters, 2..16
//   DEFAULT_MASTER - index granted when no eligible request exists (< NUM_MASTERS)
//   ARB_MODE       - 0 = fixed priority (lowest index wins), 1 = round-robin
//
// Ports:
//   HCLK       in   bus clock, all state changes on its rising edge
//   HRESETn    in   asynchronous active-low reset
//   HBUSREQx   in   per-master bus request
//   HLOCKx     in   per-master locked-transfer request
//   HSPLIT     in   split-release bits (OR of all slaves), bit i unmasks master i
//   HREADY     in   transfer done / ready from the selected slave
//   HRESP      in   slave response, 2'b11 = SPLIT
//   HGRANTx    out  registered one-hot grant
//   HMASTER    out  index of the master owning the current address phase
//   HMASTLOCK  out  current address phase is locked
//
// All outputs come straight from registers.

module ahb_arbiter_param #(
    parameter int unsigned NUM_MASTERS    = 16,
    parameter int unsigned DEFAULT_MASTER = 0,
    parameter int unsigned ARB_MODE       = 0
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic [NUM_MASTERS-1:0] HBUSREQx,
    input  logic [NUM_MASTERS-1:0] HLOCKx,
    input  logic [NUM_MASTERS-1:0] HSPLIT,
    input  logic                   HREADY,
    input  logic [1:0]             HRESP,
    output logic [NUM_MASTERS-1:0] HGRANTx,
    output logic [3:0]             HMASTER,
    output logic                   HMASTLOCK
);

    localparam logic [NUM_MASTERS-1:0] DefGrant = NUM_MASTERS'(1) << DEFAULT_MASTER;
    localparam logic [3:0]             DefIdx   = 4'(DEFAULT_MASTER);
    localparam logic [3:0]             LastIdx  = 4'(NUM_MASTERS - 1);
    localparam logic [1:0]             RespSplit = 2'b11;

    // Registered state
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [3:0]             hmaster_q, hmaster_d;
    logic                   hmastlock_q, hmastlock_d;
    logic [NUM_MASTERS-1:0] split_mask_q, split_mask_d;
    logic [3:0]             rr_ptr_q, rr_ptr_d;

    // Decoded current grant
    logic [3:0]             g_idx;
    logic                   lock_g;

    // Arbitration control
    logic                   split_set;
    logic                   lock_hold;
    logic                   arb_cycle;
    logic [NUM_MASTERS-1:0] eligible;
    logic [NUM_MASTERS-1:0] above_ptr;
    logic [NUM_MASTERS-1:0] eligible_hi;
    logic [3:0]             win_idx;
    logic                   win_real;

    // Lowest set index of a request vector; 0 when empty (callers guard on empty).
    function automatic logic [3:0] lowest_idx(input logic [NUM_MASTERS-1:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

    // Encode the one-hot grant and pick up that master's lock request.
    always_comb begin
        g_idx  = '0;
        lock_g = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_q[i]) begin
                g_idx  = 4'(i);
                lock_g = HLOCKx[i];
            end
        end
    end

    // A locked sequence keeps its grant, plus one further address phase after the
    // lock request drops (HMASTLOCK still high covers that last phase).
    assign split_set = ~HREADY & (HRESP == RespSplit);
    assign lock_hold = lock_g | hmastlock_q;
    assign arb_cycle = HREADY & ~lock_hold & ~split_set;
    assign eligible  = HBUSREQx & ~split_mask_q;

    // Round-robin: masters strictly above rr_ptr are searched first, then the
    // remainder from 0 upwards. The last winner (at rr_ptr) is therefore last.
    always_comb begin
        above_ptr = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            above_ptr[i] = (4'(i) > rr_ptr_q);
        end
    end

    assign eligible_hi = eligible & above_ptr;

    always_comb begin
        win_real = (eligible != '0);
        win_idx  = DefIdx;
        if (win_real) begin
            if (ARB_MODE == 1) begin
                if (eligible_hi != '0) begin
                    win_idx = lowest_idx(eligible_hi);
                end else begin
                    win_idx = lowest_idx(eligible);
                end
            end else begin
                win_idx = lowest_idx(eligible);
            end
        end
    end

    // Next-state for grant and round-robin pointer. The default master is granted
    // with no eligible request, even if it is split-masked (acts as idle master).
    always_comb begin
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        if (arb_cycle) begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                grant_d[i] = (4'(i) == win_idx);
            end
            if (win_real) begin
                rr_ptr_d = win_idx;
            end
        end
    end

    // Address-phase owner advances on every completed transfer.
    always_comb begin
        hmaster_d   = hmaster_q;
        hmastlock_d = hmastlock_q;
        if (HREADY) begin
            hmaster_d   = g_idx;
            hmastlock_d = lock_g;
        end
    end

    // Split mask: release by HSPLIT, set by the first SPLIT response cycle.
    // Set is applied after clear so a simultaneous set wins.
    always_comb begin
        split_mask_d = split_mask_q & ~HSPLIT;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (split_set && (hmaster_q == 4'(i))) begin
                split_mask_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            grant_q      <= DefGrant;
            hmaster_q    <= DefIdx;
            hmastlock_q  <= 1'b0;
            split_mask_q <= '0;
            rr_ptr_q     <= LastIdx;
        end else begin
            grant_q      <= grant_d;
            hmaster_q    <= hmaster_d;
            hmastlock_q  <= hmastlock_d;
            split_mask_q <= split_mask_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    assign HGRANTx   = grant_q;
    assign HMASTER   = hmaster_q;
    assign HMASTLOCK = hmastlock_q;

endmodule
